multiport_regfile: RTL and testbench
====================================

MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 4, giving the register count DEPTH = 2**ADDR_W.
REQ-003 The block SHALL have parameter ZERO_REG, default 1; when 1, register 0 reads 0 and ignores writes.
REQ-004 The block SHALL have parameter SPEC_IDX, default DEPTH-1, selecting the register driven on spec_data.
REQ-005 The block SHALL have these ports (name, direction, width, meaning):
- clk in 1: clock.
- rst in 1: reset, asynchronous, active-low.
- rd_addr_a, rd_addr_b in ADDR_W: read addresses.
- rd_data_a, rd_data_b out DATA_W: read data.
- wr_en1, wr_en2 in 1: write enables.
- wr_addr1, wr_addr2 in ADDR_W: write addresses.
- wr_data1, wr_data2 in DATA_W: write data.
- spec_data out DATA_W: always shows register SPEC_IDX, including bypass.
- mark_en in 1, mark_addr in ADDR_W: set the scoreboard pending bit for an issuing producer.
- busy_a, busy_b out 1: pending bit of rd_addr_a and rd_addr_b.
- clr_req in 1: request a bulk clear.
- clr_busy out 1: a clear sweep is in progress.

Function
REQ-006 Reads SHALL be combinational; stored value, or bypass value per REQ-007, same cycle.
REQ-007 Bypass: a read address matching an enabled write port SHALL return that port's wr_data; if both ports match, port 2 wins.
REQ-008 Writes SHALL commit on the rising clk edge; on an address collision with both ports enabled, port 2's data SHALL be stored.
REQ-009 With ZERO_REG=1, address 0 SHALL read 0, SHALL NOT bypass, SHALL ignore writes, and SHALL never become pending.
REQ-010 The scoreboard SHALL hold one pending bit per register:
- set at the edge after mark_en;
- cleared at the edge after an enabled write to that address.
- If a mark and a write hit the same address in one cycle, the mark SHALL win (bit ends at 1).
REQ-011 busy_a/busy_b SHALL show the stored pending bit, forced to 0 in a cycle when that address is being written (bypass visible).
REQ-012 The clear FSM SHALL have states IDLE and CLEAR, with a count register of ADDR_W bits.
REQ-013 IDLE to CLEAR SHALL occur at the edge where clr_req=1 in IDLE; count SHALL be 0.
REQ-014 In CLEAR, each edge SHALL zero register[count] and its pending bit, then increment count.
REQ-015 When count reaches DEPTH-1, that edge SHALL clear the last entry and return to IDLE; a sweep therefore takes exactly DEPTH cycles.
REQ-016 clr_busy SHALL be 1 exactly while the state is CLEAR.
REQ-017 In CLEAR, the following SHALL be ignored: port writes, marks, and clr_req.
REQ-018 In CLEAR, reads SHALL return stored contents with no bypass.
REQ-019 Count wrap SHALL NOT occur; count is 0 whenever the state is IDLE.

Reset
REQ-020 When rst=0, asynchronously:
- all registers SHALL be 0;
- all pending bits SHALL be 0;
- the state SHALL be IDLE, with count 0.
REQ-021 During reset, outputs SHALL be: rd_data_a/b and spec_data 0 (no bypass while rst=0), busy_a/b 0, clr_busy 0.
REQ-022 Reset asserted mid-sweep SHALL abort the sweep; it SHALL NOT resume after release.

Verification
REQ-023 Write R3=0x1234 on port 1, reading R3 on port A in the same cycle: rd_data_a=0x1234 before the edge; it remains 0x1234 after the edge with wr_en1=0.
REQ-024 Port 1 writes R5=0xAAAA and port 2 writes R5=0x5555 in the same cycle: bypass reads 0x5555; stored R5=0x5555.
REQ-025 With ZERO_REG=1, write R0=0xFFFF and mark R0: rd_data_a=0 and busy_a=0 both before and after the edge.
REQ-026 Mark R7, then write R7 the next cycle: busy_a=1 for one cycle, 0 during the write cycle, stays 0 after. A simultaneous mark and write to R7 leaves busy_a=1.
REQ-027 Fill R1..R15 with nonzero values, then pulse clr_req:
- clr_busy=1 for exactly 16 cycles;
- a wr_en1 of R2=0x9999 during the sweep is dropped;
- all registers read 0 afterwards.
REQ-028 Assert rst low at sweep cycle 6: clr_busy=0 immediately and all registers read 0; no sweep activity after release.

Source files
------------

// File: rtl/multiport_regfile.sv
// rtl/multiport_regfile.sv - two-read/two-write register file with bypass, scoreboard and bulk clear
module multiport_regfile #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1,
  parameter int SPEC_IDX = (2**ADDR_W) - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en1,
  input  logic              wr_en2,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [ADDR_W-1:0] wr_addr2,
  input  logic [DATA_W-1:0] wr_data1,
  input  logic [DATA_W-1:0] wr_data2,
  output logic [DATA_W-1:0] spec_data,
  input  logic              mark_en,
  input  logic [ADDR_W-1:0] mark_addr,
  output logic              busy_a,
  output logic              busy_b,
  input  logic              clr_req,
  output logic              clr_busy
);

  localparam int              DEPTH  = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] SPEC_A = ADDR_W'(SPEC_IDX);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);
  localparam bit              ZR     = (ZERO_REG != 0);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  count;
  logic [DATA_W-1:0]  regs [DEPTH];
  logic [DEPTH-1:0]   pend;

  logic idle;
  logic we1, we2, mk;

  // Qualified write/mark strobes: only in IDLE, never to the hardwired zero register
  always_comb begin
    idle = (state == IDLE);
    we1  = wr_en1  & idle & ~(ZR && (wr_addr1  == '0));
    we2  = wr_en2  & idle & ~(ZR && (wr_addr2  == '0));
    mk   = mark_en & idle & ~(ZR && (mark_addr == '0));
  end

  // Read value for one address: zero in reset or for R0, else port-2 bypass, port-1 bypass, stored
  function automatic logic [DATA_W-1:0] read_val(
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] stored,
    input logic              live,
    input logic              e1,
    input logic [ADDR_W-1:0] a1,
    input logic [DATA_W-1:0] d1,
    input logic              e2,
    input logic [ADDR_W-1:0] a2,
    input logic [DATA_W-1:0] d2
  );
    logic [DATA_W-1:0] v;
    if (!live || (ZR && (a == '0)))
      v = '0;
    else if (e2 && (a2 == a))
      v = d2;
    else if (e1 && (a1 == a))
      v = d1;
    else
      v = stored;
    return v;
  endfunction

  // Combinational read ports, spec tap and scoreboard status with write-forwarding
  always_comb begin
    rd_data_a = read_val(rd_addr_a, regs[rd_addr_a], rst, we1, wr_addr1, wr_data1, we2, wr_addr2, wr_data2);
    rd_data_b = read_val(rd_addr_b, regs[rd_addr_b], rst, we1, wr_addr1, wr_data1, we2, wr_addr2, wr_data2);
    spec_data = read_val(SPEC_A, regs[SPEC_A], rst, we1, wr_addr1, wr_data1, we2, wr_addr2, wr_data2);
    busy_a    = rst & pend[rd_addr_a] &
                ~((we1 && (wr_addr1 == rd_addr_a)) || (we2 && (wr_addr2 == rd_addr_a)));
    busy_b    = rst & pend[rd_addr_b] &
                ~((we1 && (wr_addr1 == rd_addr_b)) || (we2 && (wr_addr2 == rd_addr_b)));
  end

  // Register and pending-bit storage: sweep clears one entry per cycle, otherwise port writes and marks
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      pend <= '0;
    end else if (!idle) begin
      regs[count] <= '0;
      pend[count] <= 1'b0;
    end else begin
      if (we1) regs[wr_addr1] <= wr_data1;
      if (we2) regs[wr_addr2] <= wr_data2;
      if (we1) pend[wr_addr1] <= 1'b0;
      if (we2) pend[wr_addr2] <= 1'b0;
      if (mk)  pend[mark_addr] <= 1'b1;
    end
  end

  // Clear sequencer: IDLE waits for clr_req, CLEAR walks count from 0 to DEPTH-1 then returns
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      count    <= '0;
      clr_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          count <= '0;
          if (clr_req) begin
            state    <= CLEAR;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          if (count == LAST_A) begin
            state    <= IDLE;
            clr_busy <= 1'b0;
            count    <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          clr_busy <= 1'b0;
          count    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiport_regfile.sv
// tb/tb_multiport_regfile.sv - directed self-checking bench for multiport_regfile
module tb_multiport_regfile;

  logic        clk;
  logic        rst;
  logic [3:0]  rd_addr_a, rd_addr_b;
  logic [15:0] rd_data_a, rd_data_b;
  logic        wr_en1, wr_en2;
  logic [3:0]  wr_addr1, wr_addr2;
  logic [15:0] wr_data1, wr_data2;
  logic [15:0] spec_data;
  logic        mark_en;
  logic [3:0]  mark_addr;
  logic        busy_a, busy_b;
  logic        clr_req;
  logic        clr_busy;

  int tests_run;
  int tests_failed;

  multiport_regfile dut (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wr_en1(wr_en1), .wr_en2(wr_en2),
    .wr_addr1(wr_addr1), .wr_addr2(wr_addr2),
    .wr_data1(wr_data1), .wr_data2(wr_data2),
    .spec_data(spec_data),
    .mark_en(mark_en), .mark_addr(mark_addr),
    .busy_a(busy_a), .busy_b(busy_b),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write1(input logic [3:0] a, input logic [15:0] d);
    wr_en1 = 1'b1; wr_addr1 = a; wr_data1 = d;
    step();
    wr_en1 = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    tests_run++;
    if (rd_data_a !== 16'h0 || rd_data_b !== 16'h0 || spec_data !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_rd: a=%h b=%h spec=%h want 0", rd_data_a, rd_data_b, spec_data);
    end
    tests_run++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0 || clr_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: busy_a=%b busy_b=%b clr_busy=%b want 0", busy_a, busy_b, clr_busy);
    end
    step();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_bypass();
    rd_addr_a = 4'd3;
    wr_en1 = 1'b1; wr_addr1 = 4'd3; wr_data1 = 16'h1234;
    #1;
    tests_run++;
    if (rd_data_a !== 16'h1234) begin
      tests_failed++;
      $display("FAIL bypass_pre: got %h want 1234", rd_data_a);
    end
    step();
    wr_en1 = 1'b0;
    #1;
    tests_run++;
    if (rd_data_a !== 16'h1234) begin
      tests_failed++;
      $display("FAIL bypass_post: got %h want 1234", rd_data_a);
    end
    wr_en2 = 1'b1; wr_addr2 = 4'd15; wr_data2 = 16'hBEEF;
    #1;
    tests_run++;
    if (spec_data !== 16'hBEEF) begin
      tests_failed++;
      $display("FAIL spec_bypass: got %h want beef", spec_data);
    end
    step();
    wr_en2 = 1'b0;
    #1;
    tests_run++;
    if (spec_data !== 16'hBEEF) begin
      tests_failed++;
      $display("FAIL spec_stored: got %h want beef", spec_data);
    end
  endtask

  task automatic test_collision();
    rd_addr_b = 4'd5;
    wr_en1 = 1'b1; wr_addr1 = 4'd5; wr_data1 = 16'hAAAA;
    wr_en2 = 1'b1; wr_addr2 = 4'd5; wr_data2 = 16'h5555;
    #1;
    tests_run++;
    if (rd_data_b !== 16'h5555) begin
      tests_failed++;
      $display("FAIL collide_bypass: got %h want 5555", rd_data_b);
    end
    step();
    wr_en1 = 1'b0; wr_en2 = 1'b0;
    #1;
    tests_run++;
    if (rd_data_b !== 16'h5555) begin
      tests_failed++;
      $display("FAIL collide_stored: got %h want 5555", rd_data_b);
    end
  endtask

  task automatic test_zero_reg();
    rd_addr_a = 4'd0;
    wr_en1 = 1'b1; wr_addr1 = 4'd0; wr_data1 = 16'hFFFF;
    mark_en = 1'b1; mark_addr = 4'd0;
    #1;
    tests_run++;
    if (rd_data_a !== 16'h0 || busy_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_pre: data=%h busy=%b want 0/0", rd_data_a, busy_a);
    end
    step();
    wr_en1 = 1'b0; mark_en = 1'b0;
    #1;
    tests_run++;
    if (rd_data_a !== 16'h0 || busy_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_post: data=%h busy=%b want 0/0", rd_data_a, busy_a);
    end
  endtask

  task automatic test_scoreboard();
    rd_addr_a = 4'd7; rd_addr_b = 4'd7;
    mark_en = 1'b1; mark_addr = 4'd7;
    #1;
    tests_run++;
    if (busy_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL sb_before_mark: got %b want 0", busy_a);
    end
    step();
    mark_en = 1'b0;
    #1;
    tests_run++;
    if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
      tests_failed++;
      $display("FAIL sb_marked: busy_a=%b busy_b=%b want 1/1", busy_a, busy_b);
    end
    wr_en1 = 1'b1; wr_addr1 = 4'd7; wr_data1 = 16'h0077;
    #1;
    tests_run++;
    if (busy_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL sb_write_cycle: got %b want 0", busy_a);
    end
    step();
    wr_en1 = 1'b0;
    #1;
    tests_run++;
    if (busy_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL sb_after_write: got %b want 0", busy_a);
    end
    mark_en = 1'b1; mark_addr = 4'd7;
    wr_en2 = 1'b1; wr_addr2 = 4'd7; wr_data2 = 16'h0707;
    step();
    mark_en = 1'b0; wr_en2 = 1'b0;
    #1;
    tests_run++;
    if (busy_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL sb_mark_wins: got %b want 1", busy_a);
    end
    tests_run++;
    if (rd_data_a !== 16'h0707) begin
      tests_failed++;
      $display("FAIL sb_mark_wins_data: got %h want 0707", rd_data_a);
    end
  endtask

  task automatic test_clear_sweep();
    int n;
    for (int i = 1; i < 16; i++) write1(4'(i), 16'(16'h1000 + i * 16'h0111));
    rd_addr_a = 4'd9;
    #1;
    tests_run++;
    if (rd_data_a !== 16'h1999) begin
      tests_failed++;
      $display("FAIL fill_check: got %h want 1999", rd_data_a);
    end
    rd_addr_a = 4'd2;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    n = 0;
    while (clr_busy === 1'b1 && n < 40) begin
      n++;
      if (n == 5) begin
        wr_en1 = 1'b1; wr_addr1 = 4'd2; wr_data1 = 16'h9999;
        mark_en = 1'b1; mark_addr = 4'd12;
        #1;
        tests_run++;
        if (rd_data_a !== 16'h0) begin
          tests_failed++;
          $display("FAIL sweep_no_bypass: got %h want 0", rd_data_a);
        end
      end
      step();
      wr_en1 = 1'b0; mark_en = 1'b0;
    end
    tests_run++;
    if (n != 16) begin
      tests_failed++;
      $display("FAIL sweep_len: got %0d cycles want 16", n);
    end
    for (int i = 0; i < 16; i++) begin
      rd_addr_a = 4'(i);
      #1;
      tests_run++;
      if (rd_data_a !== 16'h0 || busy_a !== 1'b0) begin
        tests_failed++;
        $display("FAIL sweep_zero R%0d: data=%h busy=%b want 0/0", i, rd_data_a, busy_a);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    logic seen;
    write1(4'd9, 16'h4242);
    mark_en = 1'b1; mark_addr = 4'd9;
    step();
    mark_en = 1'b0;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (n = 1; n < 6; n++) step();
    rd_addr_a = 4'd9;
    #2;
    rst = 1'b0;
    wr_en1 = 1'b1; wr_addr1 = 4'd9; wr_data1 = 16'h5A5A;
    #1;
    tests_run++;
    if (clr_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_busy: got %b want 0", clr_busy);
    end
    tests_run++;
    if (rd_data_a !== 16'h0 || busy_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_rd: data=%h busy=%b want 0/0", rd_data_a, busy_a);
    end
    wr_en1 = 1'b0;
    step();
    rst = 1'b1;
    #1;
    tests_run++;
    if (rd_data_a !== 16'h0) begin
      tests_failed++;
      $display("FAIL midreset_cleared: got %h want 0", rd_data_a);
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (clr_busy !== 1'b0) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_resume: clr_busy=1 seen want 0");
    end
    write1(4'd4, 16'h0404);
    rd_addr_a = 4'd4;
    #1;
    tests_run++;
    if (rd_data_a !== 16'h0404) begin
      tests_failed++;
      $display("FAIL post_reset_write: got %h want 0404", rd_data_a);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b0;
    rd_addr_a = '0; rd_addr_b = '0;
    wr_en1 = 1'b0; wr_en2 = 1'b0;
    wr_addr1 = '0; wr_addr2 = '0;
    wr_data1 = '0; wr_data2 = '0;
    mark_en = 1'b0; mark_addr = '0;
    clr_req = 1'b0;

    test_reset();
    test_bypass();
    test_collision();
    test_zero_reg();
    test_scoreboard();
    test_clear_sweep();
    test_reset_mid_sweep();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
